// File: rtl/feature_extract.sv
// feature_extract: front-end of the driver-monitor pipeline.
// Turns raw speed / steering / brake samples into saturated 8-bit features
// (acceleration, jerk, steering rate, brake) once enough history exists.
// Optional feature: define FE_SMOOTH_EN to run speed through a 2-tap mean
// before differencing (adds one warm-up state and the raw-speed register).
module feature_extract #(
    parameter int STEER_DEADBAND = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] speed,
    input  logic [7:0] steer_angle,
    input  logic [7:0] brake_in,
    output logic [7:0] accel,
    output logic [7:0] jerk,
    output logic [7:0] steer,
    output logic [7:0] brake,
    output logic       out_valid,
    output logic       primed
);

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_P1    = 3'd1,
        ST_P2    = 3'd2,
`ifdef FE_SMOOTH_EN
        ST_P3    = 3'd3,
`endif
        ST_RUN   = 3'd4
    } state_t;

    // Last warm-up state: the sample accepted here is the first to produce output.
`ifdef FE_SMOOTH_EN
    localparam state_t ST_LAST = ST_P3;
`else
    localparam state_t ST_LAST = ST_P2;
`endif

    localparam logic [8:0] STEER_DB = 9'(STEER_DEADBAND);

    // Clamp a 9-bit signed difference to the 8-bit signed range.
    function automatic logic [7:0] sat8(input logic signed [8:0] v);
        if (v > 9'sd127) begin
            return 8'h7F;
        end else if (v < -9'sd128) begin
            return 8'h80;
        end else begin
            return v[7:0];
        end
    endfunction

    state_t      state_r;
    logic [7:0]  prev_speed_r;
    logic [7:0]  prev_steer_r;
    logic [7:0]  prev_accel_r;
    logic [7:0]  accel_r;
    logic [7:0]  jerk_r;
    logic [7:0]  steer_r;
    logic [7:0]  brake_r;
    logic        out_valid_r;
    logic        primed_r;
`ifdef FE_SMOOTH_EN
    logic [7:0]  prev_raw_r;
    logic [8:0]  smooth_sum_s;
`endif

    logic [7:0]        speed_eff_s;
    logic signed [8:0] speed_diff_s;
    logic [7:0]        accel_n_s;
    logic signed [8:0] jerk_diff_s;
    logic [7:0]        jerk_n_s;
    logic signed [8:0] steer_diff_s;
    logic [7:0]        steer_sat_s;
    logic [8:0]        steer_mag_s;
    logic [7:0]        steer_n_s;
    logic              emit_s;

    // Feature arithmetic for the sample currently on the inputs.
    always_comb begin
`ifdef FE_SMOOTH_EN
        smooth_sum_s = {1'b0, speed} + {1'b0, prev_raw_r};
        speed_eff_s  = smooth_sum_s[8:1];
`else
        speed_eff_s  = speed;
`endif
        speed_diff_s = $signed({1'b0, speed_eff_s}) - $signed({1'b0, prev_speed_r});
        accel_n_s    = sat8(speed_diff_s);
        jerk_diff_s  = $signed({accel_n_s[7], accel_n_s}) - $signed({prev_accel_r[7], prev_accel_r});
        jerk_n_s     = sat8(jerk_diff_s);
        steer_diff_s = $signed({steer_angle[7], steer_angle}) - $signed({prev_steer_r[7], prev_steer_r});
        steer_sat_s  = sat8(steer_diff_s);
        // Magnitude needs 9 bits so that -128 maps to 128 rather than wrapping.
        if (steer_sat_s[7]) begin
            steer_mag_s = 9'd0 - {1'b1, steer_sat_s};
        end else begin
            steer_mag_s = {1'b0, steer_sat_s};
        end
        if (steer_mag_s <= STEER_DB) begin
            steer_n_s = 8'd0;
        end else begin
            steer_n_s = steer_sat_s;
        end
        if (in_valid && ((state_r == ST_LAST) || (state_r == ST_RUN))) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
    end

    // Warm-up FSM, sample history and registered feature outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_EMPTY;
            prev_speed_r <= 8'd0;
            prev_steer_r <= 8'd0;
            prev_accel_r <= 8'd0;
            accel_r      <= 8'd0;
            jerk_r       <= 8'd0;
            steer_r      <= 8'd0;
            brake_r      <= 8'd0;
            out_valid_r  <= 1'b0;
            primed_r     <= 1'b0;
`ifdef FE_SMOOTH_EN
            prev_raw_r   <= 8'd0;
`endif
        end else begin
            out_valid_r <= emit_s;
            if (in_valid) begin
                // History is refreshed on every accepted sample; values captured
                // during warm-up are simply overwritten before they are used.
                prev_speed_r <= speed_eff_s;
                prev_steer_r <= steer_angle;
                prev_accel_r <= accel_n_s;
`ifdef FE_SMOOTH_EN
                prev_raw_r   <= speed;
`endif
                case (state_r)
                    ST_EMPTY: state_r <= ST_P1;
                    ST_P1:    state_r <= ST_P2;
`ifdef FE_SMOOTH_EN
                    ST_P2:    state_r <= ST_P3;
                    ST_P3:    state_r <= ST_RUN;
`else
                    ST_P2:    state_r <= ST_RUN;
`endif
                    ST_RUN:   state_r <= ST_RUN;
                    default:  state_r <= ST_EMPTY;
                endcase
            end
            if (emit_s) begin
                accel_r  <= accel_n_s;
                jerk_r   <= jerk_n_s;
                steer_r  <= steer_n_s;
                brake_r  <= brake_in;
                primed_r <= 1'b1;
            end
        end
    end

    assign accel     = accel_r;
    assign jerk      = jerk_r;
    assign steer     = steer_r;
    assign brake     = brake_r;
    assign out_valid = out_valid_r;
    assign primed    = primed_r;

endmodule

// File: tb/tb_feature_extract.sv
// Self-checking bench for feature_extract: table of hand-computed vectors,
// expected features queued when a sample is driven and popped on out_valid.
module tb_feature_extract;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] speed;
    logic [7:0] steer_angle;
    logic [7:0] brake_in;
    logic [7:0] accel;
    logic [7:0] jerk;
    logic [7:0] steer;
    logic [7:0] brake;
    logic       out_valid;
    logic       primed;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] spd;
        logic [7:0] str;
        logic [7:0] brk;
        logic       ev;
        logic [7:0] ea;
        logic [7:0] ej;
        logic [7:0] es;
        logic [7:0] eb;
        logic       ep;
    } vec_t;

    typedef struct {
        logic [7:0] ea;
        logic [7:0] ej;
        logic [7:0] es;
        logic [7:0] eb;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;
    vec_t tbl[$];

    feature_extract #(.STEER_DEADBAND(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .speed      (speed),
        .steer_angle(steer_angle),
        .brake_in   (brake_in),
        .accel      (accel),
        .jerk       (jerk),
        .steer      (steer),
        .brake      (brake),
        .out_valid  (out_valid),
        .primed     (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int r, input int v, input int sp, input int st, input int br,
                                input int ev, input int ea, input int ej, input int es, input int eb,
                                input int ep);
        vec_t x;
        x.rst = 1'(r);  x.vld = 1'(v);
        x.spd = 8'(sp); x.str = 8'(st); x.brk = 8'(br);
        x.ev  = 1'(ev);
        x.ea  = 8'(ea); x.ej  = 8'(ej); x.es  = 8'(es); x.eb = 8'(eb);
        x.ep  = 1'(ep);
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst         = v.rst;
        in_valid    = v.vld;
        speed       = v.spd;
        steer_angle = v.str;
        brake_in    = v.brk;
        if (v.rst) begin
            exp_q.delete();
            held = '{8'd0, 8'd0, 8'd0, 8'd0};
        end else if (v.ev) begin
            exp_q.push_back('{v.ea, v.ej, v.es, v.eb});
        end
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), int'(v.ev));
        chk("primed", int'(primed), int'(v.ep));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard: actual=out_valid required=no_pending_sample at %0t", $time);
            end else begin
                e    = exp_q.pop_front();
                held = e;
            end
        end
        chk("accel", int'($signed(accel)), int'($signed(held.ea)));
        chk("jerk",  int'($signed(jerk)),  int'($signed(held.ej)));
        chk("steer", int'($signed(steer)), int'($signed(held.es)));
        chk("brake", int'(brake),          int'(held.eb));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; speed = 8'd0; steer_angle = 8'd0; brake_in = 8'd0;
        held = '{8'd0, 8'd0, 8'd0, 8'd0};
        //              rst vld spd  str  brk  ev  accel jerk steer brake primed
`ifndef FE_SMOOTH_EN
        tbl.push_back(mk(1, 0,   0,    0,   0, 0,    0,   0,    0,   0, 0)); // reset state
        // basic deltas
        tbl.push_back(mk(0, 1, 100,    0,   7, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1, 110,   10,   8, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1, 125,   13,   9, 1,   15,   5,    3,   9, 1));
        tbl.push_back(mk(1, 1, 200,   77,  66, 0,    0,   0,    0,   0, 0));
        // saturation + deadband, 4 back-to-back samples
        tbl.push_back(mk(0, 1,   0,   50,   1, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1,   0,   50,   2, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1, 255,   52,   3, 1,  127, 127,    0,   3, 1));
        tbl.push_back(mk(0, 1,   0,   47,   4, 1, -128,-128,   -5,   4, 1));
        // gap: outputs hold
        tbl.push_back(mk(0, 0,  33,   99,  55, 0, -128,-128,   -5,   4, 1));
        tbl.push_back(mk(0, 0, 250,  -90, 250, 0, -128,-128,   -5,   4, 1));
        tbl.push_back(mk(0, 0,   1,    1,   1, 0, -128,-128,   -5,   4, 1));
        tbl.push_back(mk(0, 0, 128, -128, 128, 0, -128,-128,   -5,   4, 1));
        tbl.push_back(mk(0, 0,  77,   12,  90, 0, -128,-128,   -5,   4, 1));
        tbl.push_back(mk(0, 1,  10,   47,   5, 1,   10, 127,    0,   5, 1));
        // reset alongside in_valid, then full warm-up again
        tbl.push_back(mk(1, 1,  99,   20,  30, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1,  20, -100,  10, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1,  30,  100,  11, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1,  10, -100,  12, 1,  -20, -30, -128,  12, 1));
        tbl.push_back(mk(0, 1, 200,  -99,  13, 1,  127, 127,    0,  13, 1));
        tbl.push_back(mk(0, 1, 190,  -96, 200, 1,  -10,-128,    3, 200, 1));
        tbl.push_back(mk(0, 1, 190,  127, 255, 1,    0,  10,  127, 255, 1));
        tbl.push_back(mk(0, 1, 190,  125,   0, 1,    0,   0,    0,   0, 1));
        tbl.push_back(mk(0, 0, 190,  125,   0, 0,    0,   0,    0,   0, 1));
`else
        tbl.push_back(mk(1, 0,   0,    0,   0, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1, 100,    5,   1, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1, 100,    5,   2, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1, 110,    5,   3, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1, 130,    5,   4, 1,   15,  10,    0,   4, 1));
        tbl.push_back(mk(0, 1, 130,   15,   5, 1,   10,  -5,   10,   5, 1));
        tbl.push_back(mk(0, 1, 131,   15,   6, 1,    0, -10,    0,   6, 1));
        tbl.push_back(mk(1, 1,  50,    0,   0, 0,    0,   0,    0,   0, 0));
        tbl.push_back(mk(0, 1,  50,    0,   7, 0,    0,   0,    0,   0, 0));
`endif
        foreach (tbl[i]) begin
            apply(tbl[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        chk("pending_expectations", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
